// File: rtl/router_fsm_if.sv
// Bundles the router input-side packet stream, FIFO status and phase strobes
// between the packet source/synchronizer side (master) and router_fsm (slave).
interface router_fsm_if;
    // Handshake: the source presents one word per cycle while pkt_valid=1 and
    // must hold that word in any cycle where busy=1; a word is written to the
    // addressed FIFO only in cycles where write_enb_reg=1.
    logic       pkt_valid;
    logic [1:0] data_in;
    logic       fifo_full;
    logic       fifo_empty_0;
    logic       fifo_empty_1;
    logic       fifo_empty_2;
    logic       soft_reset_0;
    logic       soft_reset_1;
    logic       soft_reset_2;
    logic       parity_done;
    logic       low_pkt_valid;

    logic       detect_add;
    logic       lfd_state;
    logic       ld_state;
    logic       laf_state;
    logic       full_state;
    logic       write_enb_reg;
    logic       rst_int_reg;
    logic       busy;
    logic [1:0] addr_q;
    logic [2:0] fsm_state;

    modport slave (
        input  pkt_valid, data_in, fifo_full,
        input  fifo_empty_0, fifo_empty_1, fifo_empty_2,
        input  soft_reset_0, soft_reset_1, soft_reset_2,
        input  parity_done, low_pkt_valid,
        output detect_add, lfd_state, ld_state, laf_state, full_state,
        output write_enb_reg, rst_int_reg, busy, addr_q, fsm_state
    );

    modport master (
        output pkt_valid, data_in, fifo_full,
        output fifo_empty_0, fifo_empty_1, fifo_empty_2,
        output soft_reset_0, soft_reset_1, soft_reset_2,
        output parity_done, low_pkt_valid,
        input  detect_add, lfd_state, ld_state, laf_state, full_state,
        input  write_enb_reg, rst_int_reg, busy, addr_q, fsm_state
    );
endinterface

// File: rtl/router_fsm.sv
// Packet-sequencing Moore FSM for the 1x3 router. Outputs are registered from
// the next state, so they always match the state register with no input path.
module router_fsm (
    input  logic         clk,
    input  logic         rstn,
    router_fsm_if.slave  bus
);

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        LOAD_PARITY        = 3'd3,
        FIFO_FULL_STATE    = 3'd4,
        LOAD_AFTER_FULL    = 3'd5,
        WAIT_TILL_EMPTY    = 3'd6,
        CHECK_PARITY_ERROR = 3'd7
    } state_t;

    state_t     r_state;
    logic [1:0] r_addr;
    logic       r_detect_add;
    logic       r_lfd_state;
    logic       r_ld_state;
    logic       r_laf_state;
    logic       r_full_state;
    logic       r_write_enb_reg;
    logic       r_rst_int_reg;
    logic       r_busy;

    state_t     w_next;
    logic [1:0] w_next_addr;
    logic [1:0] w_sel_idx;
    logic       w_sel_empty;
    logic       w_sel_srst;

    // The header's own address picks the empty flag while decoding.
    always_comb begin
        w_sel_idx = (r_state == DECODE_ADDRESS) ? bus.data_in : r_addr;
        case (w_sel_idx)
            2'd0:    w_sel_empty = bus.fifo_empty_0;
            2'd1:    w_sel_empty = bus.fifo_empty_1;
            2'd2:    w_sel_empty = bus.fifo_empty_2;
            default: w_sel_empty = 1'b0;
        endcase
        case (r_addr)
            2'd0:    w_sel_srst = bus.soft_reset_0;
            2'd1:    w_sel_srst = bus.soft_reset_1;
            2'd2:    w_sel_srst = bus.soft_reset_2;
            default: w_sel_srst = 1'b0;
        endcase
    end

    always_comb begin
        w_next      = r_state;
        w_next_addr = r_addr;
        if (r_state != DECODE_ADDRESS && w_sel_srst) begin
            w_next = DECODE_ADDRESS;
        end else begin
            case (r_state)
                DECODE_ADDRESS: begin
                    if (bus.pkt_valid && bus.data_in != 2'd3) begin
                        w_next_addr = bus.data_in;
                        w_next      = w_sel_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                    end
                end
                WAIT_TILL_EMPTY: if (w_sel_empty) w_next = LOAD_FIRST_DATA;
                LOAD_FIRST_DATA: w_next = LOAD_DATA;
                LOAD_DATA: begin
                    if (bus.fifo_full)       w_next = FIFO_FULL_STATE;
                    else if (!bus.pkt_valid) w_next = LOAD_PARITY;
                end
                FIFO_FULL_STATE: if (!bus.fifo_full) w_next = LOAD_AFTER_FULL;
                LOAD_AFTER_FULL: begin
                    if (bus.parity_done)        w_next = DECODE_ADDRESS;
                    else if (bus.low_pkt_valid) w_next = LOAD_PARITY;
                    else                        w_next = LOAD_DATA;
                end
                LOAD_PARITY: w_next = CHECK_PARITY_ERROR;
                CHECK_PARITY_ERROR: w_next = bus.fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
                default: w_next = DECODE_ADDRESS;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state         <= DECODE_ADDRESS;
            r_addr          <= 2'd0;
            r_detect_add    <= 1'b1;
            r_lfd_state     <= 1'b0;
            r_ld_state      <= 1'b0;
            r_laf_state     <= 1'b0;
            r_full_state    <= 1'b0;
            r_write_enb_reg <= 1'b0;
            r_rst_int_reg   <= 1'b0;
            r_busy          <= 1'b0;
        end else begin
            r_state         <= w_next;
            r_addr          <= w_next_addr;
            r_detect_add    <= (w_next == DECODE_ADDRESS);
            r_lfd_state     <= (w_next == LOAD_FIRST_DATA);
            r_ld_state      <= (w_next == LOAD_DATA);
            r_laf_state     <= (w_next == LOAD_AFTER_FULL);
            r_full_state    <= (w_next == FIFO_FULL_STATE);
            r_write_enb_reg <= (w_next == LOAD_FIRST_DATA) || (w_next == LOAD_DATA) ||
                               (w_next == LOAD_AFTER_FULL) || (w_next == LOAD_PARITY);
            r_rst_int_reg   <= (w_next == CHECK_PARITY_ERROR);
            r_busy          <= (w_next != DECODE_ADDRESS) && (w_next != LOAD_DATA);
        end
    end

    assign bus.detect_add    = r_detect_add;
    assign bus.lfd_state     = r_lfd_state;
    assign bus.ld_state      = r_ld_state;
    assign bus.laf_state     = r_laf_state;
    assign bus.full_state    = r_full_state;
    assign bus.write_enb_reg = r_write_enb_reg;
    assign bus.rst_int_reg   = r_rst_int_reg;
    assign bus.busy          = r_busy;
    assign bus.addr_q        = r_addr;
    assign bus.fsm_state     = r_state;

endmodule

// File: tb/tb_router_fsm.sv
// Directed-vector bench for router_fsm; outputs sampled 1ns after each rising edge.
module tb_router_fsm;

    logic clk;
    logic rstn;
    int   n_tests;
    int   n_fail;

    router_fsm_if ifc ();

    router_fsm dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (ifc.slave)
    );

    // {detect_add, lfd, ld, laf, full, write_enb_reg, rst_int_reg, busy}
    localparam logic [7:0] E_DA  = 8'b1000_0000;
    localparam logic [7:0] E_WT  = 8'b0000_0001;
    localparam logic [7:0] E_LFD = 8'b0100_0101;
    localparam logic [7:0] E_LD  = 8'b0010_0100;
    localparam logic [7:0] E_FUL = 8'b0000_1001;
    localparam logic [7:0] E_LAF = 8'b0001_0101;
    localparam logic [7:0] E_LP  = 8'b0000_0101;
    localparam logic [7:0] E_CPE = 8'b0000_0011;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] outs();
        return {ifc.detect_add, ifc.lfd_state, ifc.ld_state, ifc.laf_state,
                ifc.full_state, ifc.write_enb_reg, ifc.rst_int_reg, ifc.busy};
    endfunction

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic tick_chk(input string tag, input logic [7:0] e_outs, input logic [1:0] e_addr);
        @(posedge clk);
        #1;
        check(tag, outs(), e_outs);
        check({tag, "_addr"}, {6'd0, ifc.addr_q}, {6'd0, e_addr});
    endtask

    task automatic idle();
        ifc.pkt_valid     = 1'b0;
        ifc.data_in       = 2'd0;
        ifc.fifo_full     = 1'b0;
        ifc.fifo_empty_0  = 1'b1;
        ifc.fifo_empty_1  = 1'b1;
        ifc.fifo_empty_2  = 1'b1;
        ifc.soft_reset_0  = 1'b0;
        ifc.soft_reset_1  = 1'b0;
        ifc.soft_reset_2  = 1'b0;
        ifc.parity_done   = 1'b0;
        ifc.low_pkt_valid = 1'b0;
    endtask

    task automatic header(input logic [1:0] a);
        ifc.pkt_valid = 1'b1;
        ifc.data_in   = a;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;

        // Reset with random inputs
        rstn = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ifc.pkt_valid     = 1'($urandom_range(0, 1));
            ifc.data_in       = 2'($urandom_range(0, 3));
            ifc.fifo_full     = 1'($urandom_range(0, 1));
            ifc.fifo_empty_0  = 1'($urandom_range(0, 1));
            ifc.fifo_empty_1  = 1'($urandom_range(0, 1));
            ifc.fifo_empty_2  = 1'($urandom_range(0, 1));
            ifc.soft_reset_0  = 1'($urandom_range(0, 1));
            ifc.soft_reset_1  = 1'($urandom_range(0, 1));
            ifc.soft_reset_2  = 1'($urandom_range(0, 1));
            ifc.parity_done   = 1'($urandom_range(0, 1));
            ifc.low_pkt_valid = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            check("rst_outs", outs(), E_DA);
            check("rst_addr", {6'd0, ifc.addr_q}, 8'd0);
        end
        idle();
        @(negedge clk);
        rstn = 1'b1;
        tick_chk("idle", E_DA, 2'd0);

        // Normal packet to port 1: header at edge 0, pkt_valid low at edge 4
        header(2'd1);
        tick_chk("n_lfd1", E_LFD, 2'd1);
        ifc.data_in = 2'd3;
        tick_chk("n_ld2", E_LD, 2'd1);
        tick_chk("n_ld3", E_LD, 2'd1);
        tick_chk("n_ld4", E_LD, 2'd1);
        ifc.pkt_valid = 1'b0;
        tick_chk("n_lp5", E_LP, 2'd1);
        tick_chk("n_cpe6", E_CPE, 2'd1);
        tick_chk("n_da7", E_DA, 2'd1);

        // Busy port 2 waits until empty
        ifc.fifo_empty_2 = 1'b0;
        header(2'd2);
        tick_chk("b_wt1", E_WT, 2'd2);
        for (int i = 2; i <= 5; i++) tick_chk("b_wt", E_WT, 2'd2);
        ifc.fifo_empty_2 = 1'b1;
        tick_chk("b_lfd6", E_LFD, 2'd2);
        ifc.pkt_valid = 1'b0;
        tick_chk("b_ld", E_LD, 2'd2);
        tick_chk("b_lp", E_LP, 2'd2);
        tick_chk("b_cpe", E_CPE, 2'd2);
        tick_chk("b_da", E_DA, 2'd2);

        // Full stall with pkt_valid falling on the same edge; resume via low_pkt_valid
        header(2'd0);
        tick_chk("f_lfd", E_LFD, 2'd0);
        tick_chk("f_ld", E_LD, 2'd0);
        ifc.fifo_full = 1'b1;
        ifc.pkt_valid = 1'b0;
        tick_chk("f_full1", E_FUL, 2'd0);
        tick_chk("f_full2", E_FUL, 2'd0);
        ifc.fifo_full     = 1'b0;
        ifc.low_pkt_valid = 1'b1;
        tick_chk("f_laf", E_LAF, 2'd0);
        tick_chk("f_lp", E_LP, 2'd0);
        ifc.low_pkt_valid = 1'b0;
        ifc.fifo_full     = 1'b1;
        tick_chk("f_cpe", E_CPE, 2'd0);
        tick_chk("f_cpe_full", E_FUL, 2'd0);
        ifc.fifo_full = 1'b0;
        ifc.parity_done = 1'b1;
        tick_chk("f_laf2", E_LAF, 2'd0);
        tick_chk("f_pd_da", E_DA, 2'd0);
        ifc.parity_done = 1'b0;

        // LAF with neither flag returns to LOAD_DATA
        header(2'd2);
        tick_chk("g_lfd", E_LFD, 2'd2);
        ifc.fifo_full = 1'b1;
        tick_chk("g_ld", E_LD, 2'd2);
        tick_chk("g_full", E_FUL, 2'd2);
        ifc.fifo_full = 1'b0;
        tick_chk("g_laf", E_LAF, 2'd2);
        tick_chk("g_ld2", E_LD, 2'd2);
        ifc.pkt_valid = 1'b0;
        tick_chk("g_lp", E_LP, 2'd2);
        tick_chk("g_cpe", E_CPE, 2'd2);
        tick_chk("g_da", E_DA, 2'd2);

        // Soft reset from LOAD_DATA; other ports ignored; new header at K+1
        header(2'd0);
        tick_chk("s_lfd", E_LFD, 2'd0);
        tick_chk("s_ld", E_LD, 2'd0);
        ifc.soft_reset_1 = 1'b1;
        tick_chk("s_other", E_LD, 2'd0);
        ifc.soft_reset_1 = 1'b0;
        ifc.soft_reset_0 = 1'b1;
        tick_chk("s_da", E_DA, 2'd0);
        header(2'd1);
        tick_chk("s_new_hdr", E_LFD, 2'd1);
        ifc.soft_reset_0 = 1'b0;
        tick_chk("s_ld1", E_LD, 2'd1);
        ifc.soft_reset_1 = 1'b1;
        ifc.pkt_valid    = 1'b0;
        tick_chk("s_da1", E_DA, 2'd1);
        ifc.soft_reset_1 = 1'b0;

        // Soft reset from WAIT_TILL_EMPTY
        ifc.fifo_empty_2 = 1'b0;
        header(2'd2);
        tick_chk("s_wt", E_WT, 2'd2);
        ifc.pkt_valid    = 1'b0;
        ifc.soft_reset_2 = 1'b1;
        tick_chk("s_wt_da", E_DA, 2'd2);
        ifc.soft_reset_2 = 1'b0;
        ifc.fifo_empty_2 = 1'b1;

        // Soft reset from FIFO_FULL_STATE
        header(2'd1);
        tick_chk("s2_lfd", E_LFD, 2'd1);
        ifc.fifo_full = 1'b1;
        tick_chk("s2_ld", E_LD, 2'd1);
        tick_chk("s2_full", E_FUL, 2'd1);
        ifc.soft_reset_1 = 1'b1;
        ifc.pkt_valid    = 1'b0;
        tick_chk("s2_da", E_DA, 2'd1);
        ifc.soft_reset_1 = 1'b0;
        ifc.fifo_full    = 1'b0;

        // Invalid address 3 is ignored
        header(2'd3);
        for (int i = 0; i < 4; i++) tick_chk("inv", E_DA, 2'd1);
        ifc.pkt_valid = 1'b0;

        // Asynchronous reset mid-packet
        header(2'd2);
        tick_chk("r_lfd", E_LFD, 2'd2);
        tick_chk("r_ld", E_LD, 2'd2);
        #2;
        rstn = 1'b0;
        #1;
        check("r_async_outs", outs(), E_DA);
        check("r_async_addr", {6'd0, ifc.addr_q}, 8'd0);
        idle();
        @(negedge clk);
        rstn = 1'b1;
        tick_chk("r_after", E_DA, 2'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
